// File: rtl/mlp_adc_frame_sequencer.sv
// rtl/mlp_adc_frame_sequencer.sv - ADC frame sequencer feeding a printed-MLP classifier
// Optional build macro: ADC_ROUND_EN (round-half-up quantization with saturation)
module mlp_adc_frame_sequencer #(
    parameter int N_FEAT     = 6,
    parameter int FEAT_W     = 4,
    parameter int ADC_W      = 8,
    parameter int CLS_W      = 2,
    parameter int SETTLE_CYC = 2,
    parameter int ADC_TMO    = 255
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic [((N_FEAT > 1) ? $clog2(N_FEAT) : 1)-1:0] o_adc_sel,
    output logic                       o_adc_conv,
    input  logic                       i_adc_done,
    input  logic [ADC_W-1:0]           i_adc_data,
    output logic [N_FEAT*FEAT_W-1:0]   o_mlp_inp,
    input  logic [CLS_W-1:0]           i_mlp_out,
    output logic                       o_class_valid,
    input  logic                       i_class_ready,
    output logic [CLS_W-1:0]           o_class_out,
    output logic                       o_adc_err
);

    localparam int SEL_W   = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int CNT_MAX = (ADC_TMO > SETTLE_CYC) ? ADC_TMO : SETTLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_CONV,
        S_LOAD,
        S_EVAL,
        S_PRESENT
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [CNT_W-1:0]           r_cnt;
    logic [SEL_W-1:0]           r_idx;
    logic [N_FEAT*FEAT_W-1:0]   r_shadow;
    logic [N_FEAT*FEAT_W-1:0]   r_mlp_inp;
    logic [CLS_W-1:0]           r_class_out;
    logic                       r_adc_err;
    logic                       w_conv_end;
    logic                       w_tmo;
    logic                       w_eval_end;
    logic                       w_last_feat;
    logic [FEAT_W-1:0]          w_feat;

    // Quantizer: keep the top FEAT_W bits of the raw sample
`ifdef ADC_ROUND_EN
    logic [FEAT_W:0] w_round_sum;
    assign w_round_sum = {1'b0, i_adc_data[ADC_W-1 -: FEAT_W]}
                       + {{FEAT_W{1'b0}}, i_adc_data[ADC_W-FEAT_W-1]};
    assign w_feat = w_round_sum[FEAT_W] ? {FEAT_W{1'b1}} : w_round_sum[FEAT_W-1:0];
`else
    logic w_adc_lsb_unused;
    assign w_adc_lsb_unused = ^i_adc_data[ADC_W-FEAT_W-1:0];
    assign w_feat = i_adc_data[ADC_W-1 -: FEAT_W];
`endif

    assign w_last_feat = (r_idx == SEL_W'(N_FEAT - 1));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; conversion end covers both a real done and a timeout
    always_comb begin
        w_state_nxt = r_state;
        w_conv_end  = 1'b0;
        w_tmo       = 1'b0;
        w_eval_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_SEL;
                end
            end
            S_SEL: begin
                w_state_nxt = S_CONV;
            end
            S_CONV: begin
                // a done during the pulse cycle (count 0) belongs to no conversion of ours
                if ((r_cnt != '0) && i_adc_done) begin
                    w_conv_end = 1'b1;
                end else if (r_cnt == CNT_W'(ADC_TMO)) begin
                    w_conv_end = 1'b1;
                    w_tmo      = 1'b1;
                end
                if (w_conv_end) begin
                    w_state_nxt = w_last_feat ? S_LOAD : S_SEL;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_EVAL;
            end
            S_EVAL: begin
                if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    w_eval_end  = 1'b1;
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (i_class_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Shared cycle counter: restarts on every state change, counts only in CONV and EVAL
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == S_CONV) || (r_state == S_EVAL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Frame datapath: channel index, shadow frame, error flag, classifier load and capture
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx       <= '0;
            r_shadow    <= '0;
            r_mlp_inp   <= '0;
            r_class_out <= '0;
            r_adc_err   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_idx     <= '0;
                r_adc_err <= 1'b0;
            end
            if (w_conv_end) begin
                r_shadow[FEAT_W*int'(r_idx) +: FEAT_W] <= w_tmo ? '0 : w_feat;
                if (w_tmo) begin
                    r_adc_err <= 1'b1;
                end
                // index stays on the last channel so the mux select is stable until the next frame
                if (!w_last_feat) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
            // whole-frame transfer so the classifier never sees a partially updated vector
            if (r_state == S_LOAD) begin
                r_mlp_inp <= r_shadow;
            end
            if (w_eval_end) begin
                r_class_out <= i_mlp_out;
            end
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_adc_sel     = r_idx;
    assign o_adc_conv    = (r_state == S_CONV) && (r_cnt == '0);
    assign o_mlp_inp     = r_mlp_inp;
    assign o_class_valid = (r_state == S_PRESENT);
    assign o_class_out   = r_class_out;
    assign o_adc_err     = r_adc_err;

endmodule

// File: doc/mlp_adc_frame_sequencer.md
Name: mlp_adc_frame_sequencer

Overview:
Sequential front-end that produces the packed feature vector consumed by the combinational printed-MLP classifier. It also collects the classifier's verdict.
- Steps one shared ADC across N_FEAT sensor channels and quantizes each sample to FEAT_W bits.
- Packs all samples into one frame and drives the classifier input with it.
- Waits a fixed settle time, then captures the class index and offers it downstream on a valid/ready handshake.

Parameters:
N_FEAT, 6, number of features (ADC channels) per frame
FEAT_W, 4, bits per quantized feature
ADC_W, 8, raw ADC sample width (must be > FEAT_W)
CLS_W, 2, classifier output (class index) width
SETTLE_CYC, 2, cycles allowed for classifier combinational settle (>=1)
ADC_TMO, 255, max cycles to wait for adc_done after a conversion pulse

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  request one classification frame; sampled only in IDLE
busy  out  1  high in every state except IDLE
adc_sel  out  clog2(N_FEAT)  ADC input mux channel select
adc_conv  out  1  one-cycle conversion start pulse
adc_done  in  1  ADC conversion complete; adc_data valid this cycle
adc_data  in  ADC_W  raw ADC sample
mlp_inp  out  N_FEAT*FEAT_W  packed feature vector; feature i at bits [FEAT_W*i +: FEAT_W]
mlp_out  in  CLS_W  classifier class index (combinational from mlp_inp)
class_valid  out  1  class_out valid
class_ready  in  1  downstream accepts class_out
class_out  out  CLS_W  captured class index
adc_err  out  1  sticky: at least one conversion timed out in the current frame

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. The following are all 0: busy, adc_sel, adc_conv, mlp_inp, class_valid, class_out, adc_err, feature index, timeout counter and shadow frame. Reset mid-frame aborts the frame immediately; adc_conv drops asynchronously.
- States:
  - IDLE: start=1 → SEL with idx=0, adc_err cleared.
  - SEL (1 cycle): adc_sel=idx (mux settle) → CONV.
  - CONV: adc_conv=1 in the first CONV cycle only. adc_done is sampled from the second CONV cycle onward; adc_done in the pulse cycle is ignored.
    - On adc_done: shadow[idx] ← quantize(adc_data). Then idx<N_FEAT-1 → idx+1, SEL; else → LOAD.
    - Timeout: ADC_TMO cycles after the pulse without adc_done → shadow[idx] ← 0, adc_err ← 1, advance exactly as on done.
  - LOAD (1 cycle): mlp_inp ← whole shadow frame in one transfer, so the classifier never sees a mixed frame → EVAL.
  - EVAL: SETTLE_CYC cycles. On the last cycle, class_out ← mlp_out → PRESENT.
  - PRESENT: class_valid=1 and class_out held stable until class_valid&class_ready → IDLE.
- adc_sel changes only on entry to SEL. mlp_inp changes only in LOAD and holds its value through IDLE until the next LOAD.
- Quantize (default): feature = adc_data[ADC_W-1 -: FEAT_W] (truncate LSBs, unsigned).
- adc_done outside CONV is ignored. start outside IDLE is ignored, including the cycle the PRESENT handshake completes (no back-to-back accept).
- Latency with adc_done one cycle after every pulse and SETTLE_CYC=2:
  - 3 cycles per feature, so frame capture ends at cycle 18.
  - class_valid first high in cycle 22 after the start-sampling edge.
- class_ready held high before PRESENT: handshake completes in the first PRESENT cycle.

Optional Feature:
Macro ADC_ROUND_EN.
- Defined: quantize = truncated value + adc_data[ADC_W-FEAT_W-1] (round half up), saturating at 2^FEAT_W-1.
- Undefined: pure truncation as above, with no adder or saturation logic.

Test Plan:
- Defaults, no ADC_ROUND_EN, ADC returns 0x10,0x20,0x30,0x40,0x50,0xF0 for channels 0..5 with done 1 cycle after each pulse, mlp_out=2'b10 → mlp_inp=24'hF54321, adc_sel steps 0..5, class_out=2, class_valid rises cycle 22, drops after ready.
- ADC_ROUND_EN, channel samples 0x18 and 0xF8 → features 2 and 15 (saturated); without the macro → 1 and 15.
- Channel 3 never asserts adc_done → after 255 cycles feature 3 = 0, adc_err=1, frame completes. adc_err clears on the next accepted start.
- class_ready held low 10 cycles in PRESENT with mlp_out toggling → class_out stable, class_valid high until ready. start pulsed during PRESENT is ignored.
- adc_done asserted in the pulse cycle and again in IDLE → both ignored; capture occurs only on a later in-CONV done.
- rst asserted while in CONV for channel 4 → all outputs 0 immediately. A fresh start yields a correct full frame.
